// File: rtl/mm_job_sequencer.sv
// Job sequencer for one 2x2 x 2x2 matrix multiply on the shared multiplier/regfile/adder datapath.
// Takes an operand pair, issues 8 product writes, captures 4 sums, then streams the results out.
module mm_job_sequencer #(
    parameter int EW = 3,
    parameter int PW = 2 * EW,
    parameter int SW = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            abort,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4*EW-1:0] mat_a,
    input  logic [4*EW-1:0] mat_b,
    output logic [EW-1:0]   elem_a,
    output logic [EW-1:0]   elem_b,
    output logic [3:0]      entry_idx,
    output logic            prod_wr,
    input  logic [4*SW-1:0] sum_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SW-1:0]   res_data,
    output logic [1:0]      res_addr,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_SUM  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [2:0]      step_r, step_s;
    logic [1:0]      addr_r, addr_s;
    logic [4*EW-1:0] a_r, a_s, b_r, b_s;
    logic [SW-1:0]   result_r [4];
    logic [SW-1:0]   result_s [4];
    logic            done_s;

    logic            req_ready_r, req_ready_s;
    logic            busy_r, busy_s;
    logic            prod_wr_r, prod_wr_s;
    logic [3:0]      entry_idx_r, entry_idx_s;
    logic [EW-1:0]   elem_a_r, elem_a_s, elem_b_r, elem_b_s;
    logic            res_valid_r, res_valid_s;
    logic [SW-1:0]   res_data_r, res_data_s;
    logic            done_r;

    function automatic logic [EW-1:0] pick(input logic [4*EW-1:0] m, input logic [1:0] idx);
        pick = m[idx*EW +: EW];
    endfunction

    // State, counters, latched operands and captured sums
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            step_r  <= 3'd0;
            addr_r  <= 2'd0;
            a_r     <= {(4*EW){1'b0}};
            b_r     <= {(4*EW){1'b0}};
            for (int e = 0; e < 4; e++) begin
                result_r[e] <= {SW{1'b0}};
            end
        end else begin
            state_r  <= state_s;
            step_r   <= step_s;
            addr_r   <= addr_s;
            a_r      <= a_s;
            b_r      <= b_s;
            result_r <= result_s;
        end
    end

    // Next-state logic; abort overrides every transition including a same-cycle accept
    always_comb begin
        state_s  = state_r;
        step_s   = step_r;
        addr_s   = addr_r;
        a_s      = a_r;
        b_s      = b_r;
        result_s = result_r;
        done_s   = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
            step_s  = 3'd0;
            addr_s  = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        state_s = ST_MULT;
                        step_s  = 3'd0;
                        a_s     = mat_a;
                        b_s     = mat_b;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MULT: begin
                    if (step_r == 3'd7) begin
                        state_s = ST_SUM;
                        step_s  = 3'd0;
                    end else begin
                        step_s = step_r + 3'd1;
                    end
                end
                ST_SUM: begin
                    for (int e = 0; e < 4; e++) begin
                        result_s[e] = sum_in[e*SW +: SW];
                    end
                    state_s = ST_OUT;
                    addr_s  = 2'd0;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        if (addr_r == 2'd3) begin
                            state_s = ST_IDLE;
                            addr_s  = 2'd0;
                            done_s  = 1'b1;
                        end else begin
                            addr_s = addr_r + 2'd1;
                        end
                    end else begin
                        addr_s = addr_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    step_s  = 3'd0;
                    addr_s  = 2'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so every output leaves a flop with no extra latency.
    // Slot k computes C[r] partial t: A[i][t] (bits {i,t}) times B[t][j] (bits {t,j}).
    always_comb begin
        req_ready_s = 1'b0;
        busy_s      = 1'b0;
        prod_wr_s   = 1'b0;
        entry_idx_s = 4'd0;
        elem_a_s    = {EW{1'b0}};
        elem_b_s    = {EW{1'b0}};
        res_valid_s = 1'b0;
        res_data_s  = {SW{1'b0}};
        case (state_s)
            ST_IDLE: req_ready_s = 1'b1;
            ST_MULT: begin
                busy_s      = 1'b1;
                prod_wr_s   = 1'b1;
                entry_idx_s = {1'b0, step_s};
                elem_a_s    = pick(a_s, {step_s[2], step_s[0]});
                elem_b_s    = pick(b_s, {step_s[0], step_s[1]});
            end
            ST_SUM:  busy_s = 1'b1;
            ST_OUT: begin
                busy_s      = 1'b1;
                res_valid_s = 1'b1;
                res_data_s  = result_s[addr_s];
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            prod_wr_r   <= 1'b0;
            entry_idx_r <= 4'd0;
            elem_a_r    <= {EW{1'b0}};
            elem_b_r    <= {EW{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= {SW{1'b0}};
            done_r      <= 1'b0;
        end else begin
            req_ready_r <= req_ready_s;
            busy_r      <= busy_s;
            prod_wr_r   <= prod_wr_s;
            entry_idx_r <= entry_idx_s;
            elem_a_r    <= elem_a_s;
            elem_b_r    <= elem_b_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            done_r      <= done_s;
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign prod_wr   = prod_wr_r;
    assign entry_idx = entry_idx_r;
    assign elem_a    = elem_a_r;
    assign elem_b    = elem_b_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_addr  = addr_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Bench for mm_job_sequencer: models the multiplier/regfile/adder datapath and checks each job
// against matrix-product arithmetic computed directly from the operands.
module tb_mm_job_sequencer;
    localparam int EW = 3;
    localparam int PW = 6;
    localparam int SW = 7;

    logic            clk = 1'b0;
    logic            reset, abort, req_valid, req_ready;
    logic [4*EW-1:0] mat_a, mat_b;
    logic [EW-1:0]   elem_a, elem_b;
    logic [3:0]      entry_idx;
    logic            prod_wr;
    logic [4*SW-1:0] sum_in;
    logic            res_valid, res_ready;
    logic [SW-1:0]   res_data;
    logic [1:0]      res_addr;
    logic            busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [PW-1:0] rf [8];

    localparam logic [11:0] A1 = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [11:0] B1 = {3'd0, 3'd7, 3'd6, 3'd5};

    always #5 clk = ~clk;

    mm_job_sequencer #(.EW(EW)) dut (
        .clk(clk), .reset(reset), .abort(abort), .req_valid(req_valid), .req_ready(req_ready),
        .mat_a(mat_a), .mat_b(mat_b), .elem_a(elem_a), .elem_b(elem_b), .entry_idx(entry_idx),
        .prod_wr(prod_wr), .sum_in(sum_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_addr(res_addr), .busy(busy), .done(done)
    );

    // datapath environment: multiplier into regfile, adder pairs slots 2e and 2e+1
    initial for (int s = 0; s < 8; s++) rf[s] = '0;
    always @(posedge clk) if (prod_wr) rf[entry_idx[2:0]] <= PW'(elem_a) * PW'(elem_b);
    always_comb begin
        sum_in = '0;
        for (int e = 0; e < 4; e++) sum_in[e*SW +: SW] = SW'(rf[2*e]) + SW'(rf[2*e+1]);
    end

    function automatic int el(input logic [11:0] m, input int row, input int col);
        return int'(m[(2*row+col)*EW +: EW]);
    endfunction

    function automatic int cexp(input logic [11:0] a, input logic [11:0] b, input int e);
        int r, c;
        r = e / 2; c = e % 2;
        return el(a, r, 0) * el(b, 0, c) + el(a, r, 1) * el(b, 1, c);
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [11:0] a, input logic [11:0] b);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL req_ready_wait got %b want 1", req_ready);
        end
        req_valid = 1'b1; mat_a = a; mat_b = b;
        tick();
        req_valid = 1'b0; mat_a = 12'($urandom); mat_b = 12'($urandom);
    endtask

    // mode 0: res_ready always high, 1: random res_ready, 2: three stall cycles at addr 1
    task automatic do_job(input logic [11:0] a, input logic [11:0] b, input int mode);
        logic [16:0] g17, e17;
        logic [12:0] g13, e13;
        logic [5:0]  g6, e6;
        int r, t, i, j, addr, cycles, stall;
        logic rdy;
        start_job(a, b);
        for (int k = 0; k < 8; k++) begin
            r = k / 2; t = k % 2; i = r / 2; j = r % 2;
            e17 = {1'b1, 1'b0, 1'b1, 1'b0, 4'(k), 3'(el(a, i, t)), 3'(el(b, t, j))};
            g17 = {prod_wr, req_ready, busy, res_valid, entry_idx, elem_a, elem_b};
            vectors++;
            if (g17 !== e17) begin
                miscompares++; $display("FAIL mult_k%0d got %h want %h", k, g17, e17);
            end
            req_valid = 1'($urandom_range(0, 1));
            tick();
        end
        req_valid = 1'b0;
        g6 = {prod_wr, res_valid, busy, req_ready, done, |{entry_idx, elem_a, elem_b}};
        e6 = 6'b001000;
        vectors++;
        if (g6 !== e6) begin
            miscompares++; $display("FAIL sum_cycle got %b want %b", g6, e6);
        end
        tick();
        addr = 0; cycles = 0; stall = 0;
        while (addr < 4 && cycles < 200) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else rdy = !(addr == 1 && stall < 3);
            if (mode == 2 && !rdy) stall++;
            res_ready = rdy;
            e13 = {1'b1, 2'(addr), SW'(cexp(a, b, addr)), 1'b0, 1'b1, 1'b0};
            g13 = {res_valid, res_addr, res_data, done, busy, prod_wr};
            vectors++;
            if (g13 !== e13) begin
                miscompares++; $display("FAIL out_addr%0d got %h want %h", addr, g13, e13);
            end
            tick();
            cycles++;
            if (rdy) addr++;
        end
        res_ready = 1'b0;
        vectors++;
        if (addr != 4) begin
            miscompares++; $display("FAIL out_timeout got %0d want 4", addr);
        end
        if (mode != 1) begin
            vectors++;
            if (cycles != (mode == 0 ? 4 : 7)) begin
                miscompares++; $display("FAIL out_cycles got %0d want %0d", cycles, (mode == 0 ? 4 : 7));
            end
        end
        g13 = {done, req_ready, busy, res_valid, res_data, prod_wr, 2'b00};
        e13 = {1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 2'b00};
        vectors++;
        if (g13 !== e13) begin
            miscompares++; $display("FAIL done_cycle got %h want %h", g13, e13);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; abort = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        mat_a = '0; mat_b = '0;
        repeat (3) tick();
        vectors++;
        if ({req_ready, busy, prod_wr, entry_idx, elem_a, elem_b, res_valid, res_data, res_addr, done} !== '0) begin
            miscompares++; $display("FAIL reset_outputs got nonzero want 0");
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({req_ready, busy, done} !== 3'b100) begin
            miscompares++; $display("FAIL reset_release got %b want 100", {req_ready, busy, done});
        end
    endtask

    task automatic test_abort;
        start_job(A1, B1);
        repeat (3) tick();
        vectors++;
        if ({prod_wr, entry_idx} !== 5'b1_0011) begin
            miscompares++; $display("FAIL abort_pre got %b want 10011", {prod_wr, entry_idx});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, req_ready, prod_wr, res_valid, done, entry_idx} !== 9'b0_1000_0000) begin
            miscompares++; $display("FAIL abort_idle got %b want 010000000", {busy, req_ready, prod_wr, res_valid, done, entry_idx});
        end
        for (int n = 0; n < 12; n++) begin
            vectors++;
            if ({done, res_valid, busy} !== 3'b000) begin
                miscompares++; $display("FAIL abort_quiet got %b want 000", {done, res_valid, busy});
            end
            tick();
        end
        req_valid = 1'b1; abort = 1'b1; mat_a = A1; mat_b = B1;
        tick();
        req_valid = 1'b0; abort = 1'b0;
        vectors++;
        if ({busy, req_ready, prod_wr} !== 3'b010) begin
            miscompares++; $display("FAIL abort_vs_accept got %b want 010", {busy, req_ready, prod_wr});
        end
        do_job(A1, B1, 0);
    endtask

    task automatic test_reset_mid_job;
        start_job(A1, B1);
        repeat (9) tick();
        res_ready = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({res_valid, res_addr, res_data} !== {1'b1, 2'd2, 7'd43}) begin
            miscompares++; $display("FAIL rst_pre got %h want %h", {res_valid, res_addr, res_data}, {1'b1, 2'd2, 7'd43});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({req_ready, busy, prod_wr, entry_idx, elem_a, elem_b, res_valid, res_data, res_addr, done} !== '0) begin
            miscompares++; $display("FAIL rst_mid_outputs got nonzero want 0");
        end
        reset = 1'b1; res_ready = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            vectors++;
            if ({req_ready, busy, done, res_valid} !== 4'b1000) begin
                miscompares++; $display("FAIL rst_mid_after got %b want 1000", {req_ready, busy, done, res_valid});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        do_job(A1, B1, 0);
        do_job(B1, A1, 0);
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL done_pulse_width got %b want 0", done);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 15; n++) do_job(12'($urandom), 12'($urandom), 1);
    endtask

    initial begin
        test_reset();
        do_job(A1, B1, 0);
        do_job(12'hFFF, 12'hFFF, 0);
        do_job(A1, B1, 2);
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
